// File: rtl/des_key_schedule_if.sv
// Handshake bundle between the key register (master) and the DES key-schedule engine (slave).
// Carries key load, subkey stream and status signals; clk/rst stay outside the bundle.
interface des_key_schedule_if #(
    parameter int ROUND_W = 5
);
    logic               key_valid;
    logic               key_ready;
    logic [63:0]        key;
    logic               decrypt;
    logic               abort;
    logic               subkey_valid;
    logic               subkey_ready;
    logic [47:0]        subkey;
    logic [ROUND_W-1:0] round;
    logic               last;
    logic               parity_err;

    modport master (
        output key_valid, key, decrypt, abort, subkey_ready,
        input  key_ready, subkey_valid, subkey, round, last, parity_err
    );

    modport slave (
        input  key_valid, key, decrypt, abort, subkey_ready,
        output key_ready, subkey_valid, subkey, round, last, parity_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 at key load, per-round C/D rotation, PC-2 on the registered halves.
// Streams one 48-bit subkey per handshake, in encrypt (K1..KN) or decrypt (KN..K1) order.
module des_key_schedule #(
    parameter int ROUNDS     = 16,
    parameter int ROUND_W    = 5,
    parameter bit PARITY_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Entries are DES bit numbers (1 = MSB) of the source vector.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic int cumShift(input int n);
        int s;
        s = 0;
        for (int i = 1; i <= n; i++) begin
            s += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
        end
        return s % 28;
    endfunction

    localparam int S_TOTAL = cumShift(ROUNDS);

    function automatic logic isDouble(input logic [ROUND_W-1:0] r);
        int ri;
        ri = int'(r);
        return !(ri == 1 || ri == 2 || ri == 9 || ri == 16);
    endfunction

    function automatic logic [27:0] rotL(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotR(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [27:0] rotLTotal(input logic [27:0] x);
        logic [55:0] dup;
        dup = {x, x} << S_TOTAL;
        return dup[55:28];
    endfunction

    logic [0:0]         r_state;
    logic [27:0]        r_c;
    logic [27:0]        r_d;
    logic [ROUND_W-1:0] r_round;
    logic               r_decrypt;
    logic               r_parityErr;

    logic [55:0]        w_pc1;
    logic [27:0]        w_c0;
    logic [27:0]        w_d0;
    logic [55:0]        w_cd;
    logic [47:0]        w_subkey;
    logic [ROUND_W-1:0] w_roundInc;
    logic               w_last;
    logic               w_xfer;
    logic               w_parityErr;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign w_pc1[55 - i] = bus.key[64 - PC1[i]];
    end

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign w_subkey[47 - i] = w_cd[56 - PC2[i]];
    end

    assign w_c0       = w_pc1[55:28];
    assign w_d0       = w_pc1[27:0];
    assign w_cd       = {r_c, r_d};
    assign w_roundInc = r_round + ROUND_W'(1);
    assign w_last     = r_decrypt ? (r_round == ROUND_W'(1)) : (r_round == ROUND_W'(ROUNDS));
    assign w_xfer     = (r_state == ST_RUN) && bus.subkey_ready;

    // A byte with an even number of ones violates DES odd parity.
    always_comb begin
        w_parityErr = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^bus.key[8*b +: 8]) begin
                w_parityErr = 1'b1;
            end
        end
        if (!PARITY_CHK) begin
            w_parityErr = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_c         <= '0;
            r_d         <= '0;
            r_round     <= '0;
            r_decrypt   <= 1'b0;
            r_parityErr <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (!bus.abort && bus.key_valid) begin
                r_state     <= ST_RUN;
                r_decrypt   <= bus.decrypt;
                r_parityErr <= w_parityErr;
                if (bus.decrypt) begin
                    r_c     <= rotLTotal(w_c0);
                    r_d     <= rotLTotal(w_d0);
                    r_round <= ROUND_W'(ROUNDS);
                end else begin
                    r_c     <= rotL(w_c0, 1'b0);
                    r_d     <= rotL(w_d0, 1'b0);
                    r_round <= ROUND_W'(1);
                end
            end
        end else if (bus.abort) begin
            r_state <= ST_IDLE;
        end else if (w_xfer) begin
            // Decrypt undoes the current round's shift; encrypt applies the next round's.
            if (w_last) begin
                r_state <= ST_IDLE;
            end else if (r_decrypt) begin
                r_c     <= rotR(r_c, isDouble(r_round));
                r_d     <= rotR(r_d, isDouble(r_round));
                r_round <= r_round - ROUND_W'(1);
            end else begin
                r_c     <= rotL(r_c, isDouble(w_roundInc));
                r_d     <= rotL(r_d, isDouble(w_roundInc));
                r_round <= w_roundInc;
            end
        end
    end

    assign bus.key_ready    = (r_state == ST_IDLE);
    assign bus.subkey_valid = (r_state == ST_RUN);
    assign bus.subkey       = w_subkey;
    assign bus.round        = r_round;
    assign bus.last         = (r_state == ST_RUN) && w_last;
    assign bus.parity_err   = r_parityErr;
endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: directed DES vectors, back-pressure, abort, reset,
// parity, a ROUNDS=2 build, and random keys checked against a bit-index reference model.
module tb_des_key_schedule;
    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [47:0] obsKey [1:16];

    des_key_schedule_if #(.ROUND_W(5)) bus1 ();
    des_key_schedule_if #(.ROUND_W(2)) bus2 ();

    des_key_schedule #(.ROUNDS(16), .ROUND_W(5), .PARITY_CHK(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    des_key_schedule #(.ROUNDS(2), .ROUND_W(2), .PARITY_CHK(1'b1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Subkey n: rotate C0/D0 by the cumulative schedule using index arithmetic, then select PC-2 bits.
    function automatic logic [47:0] refSubkey(input logic [63:0] k, input int n);
        int s;
        logic [1:56] cd0;
        logic [1:56] cdn;
        logic [1:48] sk;
        s = 0;
        for (int r = 1; r <= n; r++) s += SCHED[r-1];
        for (int i = 1; i <= 56; i++) cd0[i] = k[64 - PC1[i-1]];
        for (int i = 1; i <= 28; i++) begin
            cdn[i]      = cd0[((i - 1 + s) % 28) + 1];
            cdn[28 + i] = cd0[28 + ((i - 1 + s) % 28) + 1];
        end
        for (int j = 1; j <= 48; j++) sk[j] = cdn[PC2[j-1]];
        return sk;
    endfunction

    function automatic logic refParity(input logic [63:0] k);
        int ones;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(k[8*b + i]);
            if (ones % 2 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offer a key for one cycle (called at a negedge), then scramble the key inputs.
    task automatic applyStimulus(input logic [63:0] k, input logic dec);
        bus1.key       = k;
        bus1.decrypt   = dec;
        bus1.key_valid = 1'b1;
        @(negedge clk);
        bus1.key_valid = 1'b0;
        bus1.key       = {$urandom, $urandom};
        bus1.decrypt   = ~dec;
    endtask

    task automatic runKey(input logic [63:0] k, input logic dec, input bit randReady);
        int   idx;
        int   budget;
        int   expRound;
        logic rdy;
        idx    = 0;
        budget = 0;
        checkOutput("key_ready_before", 64'(bus1.key_ready), 64'(1));
        applyStimulus(k, dec);
        checkOutput("parity_err", 64'(bus1.parity_err), 64'(refParity(k)));
        while (idx < 16 && budget < 400) begin
            expRound = dec ? 16 - idx : idx + 1;
            checkOutput("subkey_valid", 64'(bus1.subkey_valid), 64'(1));
            checkOutput("round", 64'(bus1.round), 64'(expRound));
            checkOutput("subkey", 64'(bus1.subkey), 64'(refSubkey(k, expRound)));
            checkOutput("last", 64'(bus1.last), 64'(idx == 15));
            obsKey[expRound] = bus1.subkey;
            rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            bus1.subkey_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            budget++;
        end
        bus1.subkey_ready = 1'b0;
        checkOutput("transfer_count", 64'(idx), 64'(16));
        checkOutput("key_ready_after", 64'(bus1.key_ready), 64'(1));
        checkOutput("subkey_valid_after", 64'(bus1.subkey_valid), 64'(0));
    endtask

    task automatic drainRun(input int startCount, input string tag);
        int cnt;
        int budget;
        cnt    = startCount;
        budget = 0;
        bus1.subkey_ready = 1'b1;
        while (bus1.subkey_valid && budget < 100) begin
            cnt++;
            @(negedge clk);
            budget++;
        end
        bus1.subkey_ready = 1'b0;
        checkOutput(tag, 64'(cnt), 64'(16));
    endtask

    initial begin
        logic [63:0] k2;
        rst = 1'b1;
        bus1.key_valid = 1'b0; bus1.key = '0; bus1.decrypt = 1'b0; bus1.abort = 1'b0; bus1.subkey_ready = 1'b0;
        bus2.key_valid = 1'b0; bus2.key = '0; bus2.decrypt = 1'b0; bus2.abort = 1'b0; bus2.subkey_ready = 1'b0;
        #1;
        checkOutput("rst_key_ready", 64'(bus1.key_ready), 64'(1));
        checkOutput("rst_subkey_valid", 64'(bus1.subkey_valid), 64'(0));
        checkOutput("rst_round", 64'(bus1.round), 64'(0));
        checkOutput("rst_last", 64'(bus1.last), 64'(0));
        checkOutput("rst_parity_err", 64'(bus1.parity_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] encrypt vector");
        runKey(KEY_GOOD, 1'b0, 1'b0);
        checkOutput("enc_K1", 64'(obsKey[1]), 64'(K1));
        checkOutput("enc_K2", 64'(obsKey[2]), 64'(K2));
        checkOutput("enc_K16", 64'(obsKey[16]), 64'(K16));
        checkOutput("enc_parity", 64'(bus1.parity_err), 64'(0));

        $display("[TB] decrypt vector");
        runKey(KEY_GOOD, 1'b1, 1'b0);
        checkOutput("dec_K16", 64'(obsKey[16]), 64'(K16));
        checkOutput("dec_K2", 64'(obsKey[2]), 64'(K2));
        checkOutput("dec_K1", 64'(obsKey[1]), 64'(K1));

        $display("[TB] back-pressure");
        applyStimulus(KEY_GOOD, 1'b0);
        bus1.subkey_ready = 1'b1;
        @(negedge clk);
        bus1.subkey_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_subkey", 64'(bus1.subkey), 64'(K2));
            checkOutput("bp_hold_round", 64'(bus1.round), 64'(2));
            @(negedge clk);
        end
        bus1.subkey_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_next_round", 64'(bus1.round), 64'(3));
        checkOutput("bp_next_subkey", 64'(bus1.subkey), 64'(refSubkey(KEY_GOOD, 3)));
        drainRun(2, "bp_transfer_count");

        $display("[TB] abort");
        @(negedge clk);
        applyStimulus(KEY_GOOD, 1'b0);
        bus1.subkey_ready = 1'b1;
        for (int b = 0; b < 50 && bus1.round != 5'd7; b++) @(negedge clk);
        checkOutput("abort_reach7", 64'(bus1.round), 64'(7));
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        bus1.subkey_ready = 1'b0;
        checkOutput("abort_key_ready", 64'(bus1.key_ready), 64'(1));
        checkOutput("abort_subkey_valid", 64'(bus1.subkey_valid), 64'(0));
        k2 = {$urandom, $urandom};
        applyStimulus(k2, 1'b0);
        checkOutput("abort_new_round", 64'(bus1.round), 64'(1));
        checkOutput("abort_new_subkey", 64'(bus1.subkey), 64'(refSubkey(k2, 1)));
        drainRun(0, "abort_new_transfers");

        $display("[TB] async reset and parity");
        @(negedge clk);
        applyStimulus(KEY_GOOD, 1'b0);
        bus1.subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_subkey_valid", 64'(bus1.subkey_valid), 64'(0));
        checkOutput("arst_key_ready", 64'(bus1.key_ready), 64'(1));
        checkOutput("arst_round", 64'(bus1.round), 64'(0));
        checkOutput("arst_last", 64'(bus1.last), 64'(0));
        checkOutput("arst_subkey", 64'(bus1.subkey), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        bus1.subkey_ready = 1'b0;
        @(negedge clk);
        checkOutput("arst_no_more", 64'(bus1.subkey_valid), 64'(0));
        runKey(KEY_BAD, 1'b0, 1'b0);
        checkOutput("parity_bad_hold", 64'(bus1.parity_err), 64'(1));

        $display("[TB] random keys with random back-pressure");
        for (int n = 0; n < 10; n++) begin
            runKey({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] ROUNDS=2 decrypt");
        bus2.key = KEY_GOOD;
        bus2.decrypt = 1'b1;
        bus2.key_valid = 1'b1;
        @(negedge clk);
        bus2.key_valid = 1'b0;
        checkOutput("r2_first_subkey", 64'(bus2.subkey), 64'(K2));
        checkOutput("r2_first_round", 64'(bus2.round), 64'(2));
        checkOutput("r2_first_last", 64'(bus2.last), 64'(0));
        bus2.subkey_ready = 1'b1;
        @(negedge clk);
        checkOutput("r2_second_subkey", 64'(bus2.subkey), 64'(K1));
        checkOutput("r2_second_round", 64'(bus2.round), 64'(1));
        checkOutput("r2_second_last", 64'(bus2.last), 64'(1));
        @(negedge clk);
        bus2.subkey_ready = 1'b0;
        checkOutput("r2_idle_ready", 64'(bus2.key_ready), 64'(1));
        checkOutput("r2_idle_valid", 64'(bus2.subkey_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule engine: accepts a 64-bit key and emits one 48-bit round subkey per accepted transfer.
- Stages: PC-1 → per-round C/D rotations → PC-2.
- Supports encrypt order (K1..KN) and decrypt order (KN..K1), and a parametrised reduced round count.
- Sits between the key register and the round datapath of the DES core. Replaces the standalone combinational PC-1 stage.

Parameters:
- ROUNDS, 16, number of subkeys generated per key; legal range 1..16; standard DES uses 16.
- ROUND_W, 5, width of the round index output; must hold ROUNDS.
- PARITY_CHK, 1, 1 = check odd parity of each key byte at load; 0 = parity_err tied to 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  key offered.
- key_ready  out  1  engine idle and able to accept a key.
- key  in  64  DES key; key[63] is DES bit 1, key[0] is DES bit 64.
- decrypt  in  1  sampled with key; 1 = emit subkeys in reverse order.
- abort  in  1  synchronous flush to IDLE.
- subkey_valid  out  1  subkey presented.
- subkey_ready  in  1  consumer accepts subkey.
- subkey  out  48  current round subkey; subkey[47] is PC-2 output bit 1.
- round  out  ROUND_W  DES round number of the presented subkey (1..ROUNDS).
- last  out  1  presented subkey is the final one for this key.
- parity_err  out  1  registered at key accept; 1 if any key byte has even parity.

Behaviour:
- Reset (async assert) forces:
  - state = IDLE
  - C, D, round, subkey_valid, last, parity_err = 0
  - key_ready = 1 (it is a decode of state == IDLE)
- States:
  - IDLE: key_ready = 1, subkey_valid = 0.
  - RUN: key_ready = 0, subkey_valid = 1.
- Shift schedule, round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- S(N) = sum of the first N schedule entries, mod 28. This is an elaboration-time constant.
- Key accept (IDLE, key_valid = 1):
  - Apply PC-1 to the key, giving C0 (28 bits) and D0 (28 bits).
  - Encrypt: C,D = C0,D0 rotated left by shift(1); round = 1.
  - Decrypt: C,D = C0,D0 rotated left by S(ROUNDS); round = ROUNDS.
  - Latch the mode and parity_err; go to RUN.
  - The first subkey is valid on the next cycle (latency 1).
- subkey = PC-2 applied to the registered {C,D}. It is combinational from state, so it is stable while valid and not accepted.
- Transfer occurs when subkey_valid & subkey_ready.
  - Encrypt: if round == ROUNDS, go to IDLE. Otherwise rotate C,D left by shift(round+1) and increment round.
  - Decrypt: if round == 1, go to IDLE. Otherwise rotate C,D right by shift(round) and decrement round.
- last = 1 when (encrypt & round == ROUNDS) or (decrypt & round == 1).
- Back-pressure: while subkey_ready = 0, subkey, round and last hold their values.
- Back-to-back keys: key_ready rises the cycle after the final transfer. No key can be accepted in the same cycle as the final transfer.
- abort:
  - Has priority over a transfer; RUN → IDLE on the next edge.
  - In IDLE, abort has priority over key accept; the key is not accepted.
  - abort clears subkey_valid; C, D and round keep their values but are don't-care.
- ROUNDS = 1: single transfer, last = 1 at once; encrypt and decrypt both yield K1.
- key_valid is ignored in RUN. The key, decrypt and parity inputs are sampled only at accept.
- parity_err holds its value until the next key accept or reset.
- Async reset asserted during RUN: immediate return to IDLE, outputs cleared, no further subkeys.
- Rotations wrap modulo 28 within each of C and D independently.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, subkey_ready = 1:
  - 16 consecutive valid cycles starting 1 cycle after accept.
  - K1 = 0x1B02EFFC7072, K2 = 0x79AED9DBC9E5, K16 = 0xCB3D8B0E17F5.
  - last asserted only with round 16; key_ready back the next cycle; parity_err = 0.
- Decrypt, same key:
  - The first subkey is 0xCB3D8B0E17F5 with round 16.
  - The second-to-last subkey is 0x79AED9DBC9E5 (round 2).
  - The final subkey is 0x1B02EFFC7072 with round 1 and last = 1.
- Back-pressure, encrypt, same key:
  - Drop subkey_ready for 5 cycles at round 2; subkey holds 0x79AED9DBC9E5 and round holds 2.
  - After ready returns, round 3 follows; 16 transfers in total.
- abort:
  - Assert abort at round 7 together with subkey_ready = 1; the next cycle is IDLE, subkey_valid = 0, key_ready = 1.
  - A new key is accepted the following cycle and its sequence starts at round 1.
- Reset and parity:
  - Assert rst asynchronously mid-RUN; outputs clear without a clock edge.
  - Then load key 0x133457799BBCDFF0 (last byte has even parity) with PARITY_CHK = 1; parity_err = 1 from the cycle after accept.
- ROUNDS = 2 build, decrypt, key 0x133457799BBCDFF1: exactly two subkeys in the order 0x79AED9DBC9E5 (round 2), then 0x1B02EFFC7072 (round 1, last = 1).
